mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the combinational MEM stage. Sits between the EX/MEM and MEM/WB pipeline registers.
- Performs byte, halfword and word loads and stores over a req/ack data bus with variable latency.
- Raises a stall request while a transaction is in flight.
- Handles signed and unsigned sub-word loads, big-endian lane mapping, and DATA_W of 32 or 64.

Parameters:
- DATA_W, 32, data-bus and register width; legal values 32 or 64.
- ADDR_W, 32, bus address width.
- LANES, DATA_W/8, derived count of byte lanes; not overridable.
- OFS_W, log2(LANES), derived width of the byte-offset field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- flush_i  in  1  pipeline flush; the current instruction must not retire.
- wd_i  in  5  destination register address.
- wreg_i  in  1  register write enable.
- wdata_i  in  DATA_W  ALU result (non-memory ops).
- aluop_i  in  8  operation code from the shared package.
- mem_addr_i  in  ADDR_W  effective address.
- reg2_i  in  DATA_W  store data.
- wd_o  out  5  to MEM/WB.
- wreg_o  out  1  to MEM/WB.
- wdata_o  out  DATA_W  to MEM/WB.
- stall_req_o  out  1  hold EX/MEM and upstream stages.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  bus address, lane-aligned (low OFS_W bits zero).
- bus_sel_o  out  LANES  byte enables; MSB = lane at offset 0 (big-endian).
- bus_wdata_o  out  DATA_W  store data, replicated across lanes.
- bus_rdata_i  in  DATA_W  load data, valid with bus_ack_i.
- bus_ack_i  in  1  transaction completion, one-cycle pulse.

Behaviour:
- Operations: LB, LBU, LH, LHU, LW, SB, SH, SW. All other aluop values are non-memory ops.
- Address offset: ofs = mem_addr_i[OFS_W-1:0].
- Lane selection:
  - Byte op: lane = ofs.
  - Halfword op: lanes ofs, ofs+1; ofs[0] is ignored (forced 0).
  - Word op: 4 lanes starting at ofs with ofs[1:0] forced 0. For DATA_W=32 this is all lanes.
- Load extract: the selected lanes are concatenated big-endian, then extended to DATA_W. LB/LH sign-extend; LBU/LHU/LW zero-extend. LW sign-extends only when DATA_W=64.
- Store data: byte replicated LANES times, halfword LANES/2 times, word LANES/4 times. bus_sel_o marks only the selected lanes.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Non-memory op, or valid_i=0: pure combinational pass-through of wd_i/wreg_i/wdata_i (wreg_o = wreg_i & valid_i). stall_req_o=0.
  - valid_i=1 with memory op and flush_i=0: stall_req_o=1, wreg_o=0. Capture addr, sel, wdata, we, op, wd and wreg into registers, then go to REQ.
- REQ:
  - bus_req_o=1 and stall_req_o=1. Bus outputs are driven from the captured registers and held stable until ack.
  - On bus_ack_i: latch the extracted and extended load data, then go to DONE.
  - An ack in the first REQ cycle is legal.
- DONE:
  - stall_req_o=0. wd_o/wreg_o come from the captured values; wdata_o is the latched load data. Stores output wreg_o=0.
  - Always returns to IDLE after one cycle.
- Latency: a memory op stalls a minimum of 2 cycles and retires in the DONE cycle, 2+N cycles after acceptance, where N is the number of ack-wait cycles.
- flush_i in REQ: the bus transaction is never abandoned. Keep bus_req_o until ack, set an internal drop flag, and in DONE force wreg_o=0.
- flush_i in IDLE: no capture and no bus request; wreg_o=0.
- Spurious bus_ack_i in IDLE or DONE: ignored.
- Reset, including mid-transaction: state=IDLE and all registers cleared.
  - Outputs become 0 immediately: bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, stall_req_o, wreg_o, wd_o, wdata_o.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port excp_misalign_o (1 bit).
  - In IDLE, a halfword op with ofs[0]=1, or a word op with ofs[1:0]!=0, issues no bus request, does not stall, forces wreg_o=0 and pulses excp_misalign_o=1 for that cycle.
  - excp_misalign_o resets to 0.
- Undefined: no port; low offset bits are forced to 0 as in the lane rules.

Decomposition:
- Shared package (defines): EXE_* op codes, including the new LBU/LHU/LH/SH codes; ZeroWord; WriteEnable/ChipEnable constants; FSM state encodings.
- One natural sub-module: mem_lane_align. It is purely combinational: op + offset + data in, and sel, replicated store data and extended load data out.

Test Plan:
- DATA_W=32, LB addr 0x103, rdata 0x11223380, ack after 2 wait cycles -> sel 0001, bus_addr 0x100, wdata_o 0xFFFFFF80, wreg_o=1 in DONE; stall high for 4 cycles.
- LHU addr 0x202, rdata 0xAAAA8001, ack in the first REQ cycle -> sel 0011, wdata_o 0x00008001, 2-cycle stall.
- SB addr 0x301, reg2 0x000000A5 -> bus_we=1, sel 0100, bus_wdata 0xA5A5A5A5; DONE with wreg_o=0.
- DATA_W=64, LW addr 0x...4, rdata 0x0000000080000000 -> sel 00001111, wdata_o 0xFFFFFFFF80000000.
- flush_i asserted in REQ, ack 3 cycles later -> bus_req_o held until ack, DONE with wreg_o=0. Separately, rst pulsed in REQ -> bus_req_o and stall_req_o drop to 0 immediately.
- MEM_ALIGN_CHECK_EN defined, LW addr 0x402 -> no bus_req_o, excp_misalign_o=1 for one cycle, stall_req_o=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: op codes, constants,
// FSM state encoding and the load/store op decoder.
package mem_access_unit_pkg;

    localparam int unsigned OP_W       = 8;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;

    localparam logic [OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        logic      sext;
        mem_size_e size;
    } op_dec_t;

    // LW is marked signed: a no-op at 32 bits, sign-extending at 64 bits.
    function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
        op_dec_t d;
        d = '{is_mem: 1'b0, is_store: 1'b0, sext: 1'b0, size: SZ_WORD};
        case (op)
            EXE_LB_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b1, size: SZ_BYTE};
            EXE_LBU_OP: d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b0, size: SZ_BYTE};
            EXE_LH_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b1, size: SZ_HALF};
            EXE_LHU_OP: d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b0, size: SZ_HALF};
            EXE_LW_OP:  d = '{is_mem: 1'b1, is_store: 1'b0, sext: 1'b1, size: SZ_WORD};
            EXE_SB_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, size: SZ_BYTE};
            EXE_SH_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, size: SZ_HALF};
            EXE_SW_OP:  d = '{is_mem: 1'b1, is_store: 1'b1, sext: 1'b0, size: SZ_WORD};
            default:    ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane mapping: byte enables, replicated store data
// and extracted/extended load data for a given access size and byte offset.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned LANES  = DATA_W / 8,
    localparam int unsigned OFS_W  = $clog2(LANES)
) (
    input  mem_size_e          size,
    input  logic               sext,
    input  logic [OFS_W-1:0]   ofs,
    input  logic [DATA_W-1:0]  st_data,
    input  logic [DATA_W-1:0]  ld_raw,
    output logic [LANES-1:0]   sel,
    output logic [DATA_W-1:0]  st_rep,
    output logic [DATA_W-1:0]  ld_ext
);

    localparam logic [LANES-1:0] ALL_LANES = {LANES{1'b1}};

    logic [OFS_W-1:0]  ofs_eff;
    logic [DATA_W-1:0] ld_sh;

    always_comb begin
        ofs_eff = ofs;
        sel     = '0;
        st_rep  = '0;
        ld_ext  = '0;
        case (size)
            SZ_BYTE: ;
            SZ_HALF: ofs_eff[0] = 1'b0;
            default: ofs_eff[1:0] = 2'b00;
        endcase

        // Shifting lane ofs_eff to the top leaves the access at the MSBs.
        ld_sh = ld_raw << {ofs_eff, 3'b000};

        case (size)
            SZ_BYTE: begin
                sel    = ~(ALL_LANES >> 1) >> ofs_eff;
                st_rep = {LANES{st_data[7:0]}};
                if (sext) ld_ext = DATA_W'($signed(ld_sh[DATA_W-1 -: 8]));
                else      ld_ext = DATA_W'(ld_sh[DATA_W-1 -: 8]);
            end
            SZ_HALF: begin
                sel    = ~(ALL_LANES >> 2) >> ofs_eff;
                st_rep = {(LANES/2){st_data[15:0]}};
                if (sext) ld_ext = DATA_W'($signed(ld_sh[DATA_W-1 -: 16]));
                else      ld_ext = DATA_W'(ld_sh[DATA_W-1 -: 16]);
            end
            default: begin
                sel    = ~(ALL_LANES >> 4) >> ofs_eff;
                st_rep = {(LANES/4){st_data[31:0]}};
                if (sext) ld_ext = DATA_W'($signed(ld_sh[DATA_W-1 -: 32]));
                else      ld_ext = DATA_W'(ld_sh[DATA_W-1 -: 32]);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage with a req/ack data bus: byte/half/word loads and stores, stalls
// while a transaction is in flight. MEM_ALIGN_CHECK_EN adds misalignment traps.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned LANES  = DATA_W / 8,
    localparam int unsigned OFS_W  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [OP_W-1:0]       aluop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     reg2_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stall_req_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [LANES-1:0]      bus_sel_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  excp_misalign_o,
`endif
    input  logic [DATA_W-1:0]     bus_rdata_i,
    input  logic                  bus_ack_i
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [OFS_W-1:0]        ofs_q;
    logic [LANES-1:0]        sel_q;
    logic [DATA_W-1:0]       stw_q;
    logic                    we_q;
    mem_size_e               size_q;
    logic                    sext_q;
    logic [REG_ADDR_W-1:0]   wd_q;
    logic                    wreg_q;
    logic                    drop_q, drop_d;
    logic [DATA_W-1:0]       ldata_q;

    op_dec_t                 dec_in;
    logic [OFS_W-1:0]        ofs_in;
    logic                    idle_c;
    logic                    accept_c;
    logic                    misalign_c;
    mem_size_e               al_size;
    logic                    al_sext;
    logic [OFS_W-1:0]        al_ofs;
    logic [LANES-1:0]        al_sel;
    logic [DATA_W-1:0]       al_st;
    logic [DATA_W-1:0]       al_ld;

    assign dec_in = decode_op(aluop_i);
    assign ofs_in = mem_addr_i[OFS_W-1:0];
    assign idle_c = (state_q == ST_IDLE);

    // IDLE aligns the incoming op for capture; REQ aligns the captured op for load data.
    assign al_size = idle_c ? dec_in.size : size_q;
    assign al_sext = idle_c ? dec_in.sext : sext_q;
    assign al_ofs  = idle_c ? ofs_in      : ofs_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size    (al_size),
        .sext    (al_sext),
        .ofs     (al_ofs),
        .st_data (reg2_i),
        .ld_raw  (bus_rdata_i),
        .sel     (al_sel),
        .st_rep  (al_st),
        .ld_ext  (al_ld)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_c = ((dec_in.size == SZ_HALF) && ofs_in[0]) ||
                        ((dec_in.size == SZ_WORD) && (ofs_in[1:0] != 2'b00));
    assign excp_misalign_o = !rst && idle_c && valid_i && dec_in.is_mem &&
                             !flush_i && misalign_c;
`else
    assign misalign_c = 1'b0;
`endif

    // Next state and outputs; everything reads zero while rst is asserted.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        accept_c    = 1'b0;
        wd_o        = '0;
        wreg_o      = WriteDisable;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = '0;
        bus_wdata_o = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    drop_d  = 1'b0;
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    wreg_o  = wreg_i & valid_i & ~flush_i;
                    if (valid_i && dec_in.is_mem) begin
                        wreg_o = WriteDisable;
                        if (!flush_i && !misalign_c) begin
                            stall_req_o = 1'b1;
                            accept_c    = 1'b1;
                            state_d     = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    stall_req_o = 1'b1;
                    bus_req_o   = 1'b1;
                    bus_we_o    = we_q;
                    bus_addr_o  = addr_q;
                    bus_sel_o   = sel_q;
                    bus_wdata_o = stw_q;
                    if (flush_i)   drop_d  = 1'b1;
                    if (bus_ack_i) state_d = ST_DONE;
                end
                ST_DONE: begin
                    wd_o    = wd_q;
                    wdata_o = ldata_q;
                    wreg_o  = wreg_q & ~we_q & ~drop_q & ~flush_i;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and transaction capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ofs_q   <= '0;
            sel_q   <= '0;
            stw_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            drop_q  <= 1'b0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (accept_c) begin
                addr_q <= {mem_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
                ofs_q  <= ofs_in;
                sel_q  <= al_sel;
                stw_q  <= al_st;
                we_q   <= dec_in.is_store;
                size_q <= dec_in.size;
                sext_q <= dec_in.sext;
                wd_q   <= wd_i;
                wreg_q <= wreg_i;
            end
            if ((state_q == ST_REQ) && bus_ack_i) ldata_q <= al_ld;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (32-bit and 64-bit instances).
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, flush, wreg, ack;
    logic [4:0]  wd;
    logic [7:0]  aluop;
    logic [31:0] wdata, addr, reg2, rdata;
    logic [4:0]  wd_o;
    logic        wreg_o, stall, breq, bwe;
    logic [31:0] wdata_o, baddr, bwdata;
    logic [3:0]  bsel;
`ifdef MEM_ALIGN_CHECK_EN
    logic        excp, excp64;
`endif

    logic        v64, flush64, wreg64, ack64;
    logic [4:0]  wd64;
    logic [7:0]  op64;
    logic [31:0] a64;
    logic [63:0] wdata64, reg2_64, r64;
    logic [4:0]  wd_o64;
    logic        wreg_o64, stall64, breq64, bwe64;
    logic [63:0] wdata_o64, bwdata64;
    logic [31:0] baddr64;
    logic [7:0]  bsel64;

    int checks = 0;
    int passes = 0;

    int          stall_cnt, req_cnt;
    logic        done_seen, held_ok, o_we, o_wreg_done, o_stall_done;
    logic [3:0]  o_sel;
    logic [31:0] o_addr, o_bwdata, o_wdata_done;
    logic [4:0]  o_wd_done;
    logic [7:0]  o_sel64;
    logic [31:0] o_addr64;
    logic [63:0] o_bwdata64, o_wdata64;
    logic        o_wreg64, done64;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .valid_i(valid), .flush_i(flush), .wd_i(wd),
        .wreg_i(wreg), .wdata_i(wdata), .aluop_i(aluop), .mem_addr_i(addr),
        .reg2_i(reg2), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stall_req_o(stall), .bus_req_o(breq), .bus_we_o(bwe), .bus_addr_o(baddr),
        .bus_sel_o(bsel), .bus_wdata_o(bwdata),
`ifdef MEM_ALIGN_CHECK_EN
        .excp_misalign_o(excp),
`endif
        .bus_rdata_i(rdata), .bus_ack_i(ack)
    );

    mem_access_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .valid_i(v64), .flush_i(flush64), .wd_i(wd64),
        .wreg_i(wreg64), .wdata_i(wdata64), .aluop_i(op64), .mem_addr_i(a64),
        .reg2_i(reg2_64), .wd_o(wd_o64), .wreg_o(wreg_o64), .wdata_o(wdata_o64),
        .stall_req_o(stall64), .bus_req_o(breq64), .bus_we_o(bwe64), .bus_addr_o(baddr64),
        .bus_sel_o(bsel64), .bus_wdata_o(bwdata64),
`ifdef MEM_ALIGN_CHECK_EN
        .excp_misalign_o(excp64),
`endif
        .bus_rdata_i(r64), .bus_ack_i(ack64)
    );

    // Drives one 32-bit memory op to completion and records what the bus and MEM/WB saw.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] st,
                          input logic [31:0] rd, input int wait_n, input int flush_cyc);
        logic ack_sent;
        ack_sent = 1'b0;
        @(negedge clk);
        valid = 1'b1; aluop = op; addr = a; reg2 = st; wd = 5'd9; wreg = 1'b1;
        wdata = 32'hDEAD_BEEF; flush = 1'b0; ack = 1'b0; rdata = rd;
        stall_cnt = 0; req_cnt = 0; done_seen = 1'b0; held_ok = 1'b1;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            #1;
            if (ack_sent) begin
                o_wreg_done = wreg_o; o_wdata_done = wdata_o; o_wd_done = wd_o;
                o_stall_done = stall; done_seen = 1'b1;
                valid = 1'b0; aluop = EXE_NOP_OP;
            end else begin
                if (stall) stall_cnt++;
                if (breq) begin
                    if (req_cnt == 0) begin
                        o_sel = bsel; o_addr = baddr; o_bwdata = bwdata; o_we = bwe;
                    end else if (bsel !== o_sel || baddr !== o_addr || bwdata !== o_bwdata || bwe !== o_we) begin
                        held_ok = 1'b0;
                    end
                    ack = (req_cnt == wait_n);
                    flush = (req_cnt == flush_cyc);
                    ack_sent = ack;
                    req_cnt++;
                end
            end
            @(negedge clk);
            ack = 1'b0; flush = 1'b0;
        end
        valid = 1'b0; aluop = EXE_NOP_OP;
    endtask

    task automatic run_op64(input logic [7:0] op, input logic [31:0] a, input logic [63:0] st,
                            input logic [63:0] rd);
        logic ack_sent;
        ack_sent = 1'b0; done64 = 1'b0;
        @(negedge clk);
        v64 = 1'b1; op64 = op; a64 = a; reg2_64 = st; r64 = rd; wreg64 = 1'b1; wd64 = 5'd4;
        for (int c = 0; c < 20 && !done64; c++) begin
            #1;
            if (ack_sent) begin
                o_wreg64 = wreg_o64; o_wdata64 = wdata_o64; done64 = 1'b1;
                v64 = 1'b0; op64 = EXE_NOP_OP;
            end else if (breq64) begin
                o_sel64 = bsel64; o_addr64 = baddr64; o_bwdata64 = bwdata64;
                ack64 = 1'b1; ack_sent = 1'b1;
            end
            @(negedge clk);
            ack64 = 1'b0;
        end
        v64 = 1'b0; op64 = EXE_NOP_OP;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; flush = 1'b0; wreg = 1'b1; wd = 5'd3; wdata = 32'h55;
        aluop = EXE_ADD_OP; addr = 0; reg2 = 0; rdata = 0; ack = 0;
        v64 = 0; flush64 = 0; wreg64 = 0; wd64 = 0; op64 = EXE_NOP_OP; a64 = 0;
        wdata64 = 0; reg2_64 = 0; r64 = 0; ack64 = 0;
        #12;
        checks++; if (wreg_o !== 1'b0) $display("FAIL rst_wreg got %b exp 0", wreg_o); else passes++;
        checks++; if (wd_o !== 5'd0) $display("FAIL rst_wd got %h exp 0", wd_o); else passes++;
        checks++; if (wdata_o !== 32'd0) $display("FAIL rst_wdata got %h exp 0", wdata_o); else passes++;
        checks++; if (stall !== 1'b0 || breq !== 1'b0) $display("FAIL rst_stall_req got %b%b exp 00", stall, breq); else passes++;
        valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        valid = 1'b1; aluop = EXE_ADD_OP; wreg = 1'b1; wd = 5'd7; wdata = 32'h0000_1234; flush = 1'b0;
        #1;
        checks++; if (wreg_o !== 1'b1) $display("FAIL pt_wreg got %b exp 1", wreg_o); else passes++;
        checks++; if (wd_o !== 5'd7) $display("FAIL pt_wd got %h exp 7", wd_o); else passes++;
        checks++; if (wdata_o !== 32'h1234) $display("FAIL pt_wdata got %h exp 1234", wdata_o); else passes++;
        checks++; if (stall !== 1'b0 || breq !== 1'b0) $display("FAIL pt_stall got %b%b exp 00", stall, breq); else passes++;
        flush = 1'b1; #1;
        checks++; if (wreg_o !== 1'b0) $display("FAIL pt_flush_wreg got %b exp 0", wreg_o); else passes++;
        flush = 1'b0; valid = 1'b0; #1;
        checks++; if (wreg_o !== 1'b0) $display("FAIL pt_invalid_wreg got %b exp 0", wreg_o); else passes++;
    endtask

    task automatic test_lb();
        run_op(EXE_LB_OP, 32'h103, 32'h0, 32'h1122_3380, 2, -1);
        checks++; if (done_seen !== 1'b1) $display("FAIL lb_timeout got %b exp 1", done_seen); else passes++;
        checks++; if (o_sel !== 4'b0001) $display("FAIL lb_sel got %b exp 0001", o_sel); else passes++;
        checks++; if (o_addr !== 32'h100) $display("FAIL lb_addr got %h exp 100", o_addr); else passes++;
        checks++; if (o_we !== 1'b0) $display("FAIL lb_we got %b exp 0", o_we); else passes++;
        checks++; if (stall_cnt !== 4) $display("FAIL lb_stall_cycles got %0d exp 4", stall_cnt); else passes++;
        checks++; if (held_ok !== 1'b1) $display("FAIL lb_bus_held got %b exp 1", held_ok); else passes++;
        checks++; if (o_wdata_done !== 32'hFFFF_FF80) $display("FAIL lb_wdata got %h exp ffffff80", o_wdata_done); else passes++;
        checks++; if (o_wreg_done !== 1'b1 || o_wd_done !== 5'd9) $display("FAIL lb_retire got %b/%h exp 1/09", o_wreg_done, o_wd_done); else passes++;
        checks++; if (o_stall_done !== 1'b0) $display("FAIL lb_done_stall got %b exp 0", o_stall_done); else passes++;
    endtask

    task automatic test_halfword();
        run_op(EXE_LHU_OP, 32'h202, 32'h0, 32'hAAAA_8001, 0, -1);
        checks++; if (o_sel !== 4'b0011) $display("FAIL lhu_sel got %b exp 0011", o_sel); else passes++;
        checks++; if (o_wdata_done !== 32'h0000_8001) $display("FAIL lhu_wdata got %h exp 00008001", o_wdata_done); else passes++;
        checks++; if (stall_cnt !== 2) $display("FAIL lhu_stall_cycles got %0d exp 2", stall_cnt); else passes++;
        run_op(EXE_LH_OP, 32'h101, 32'h0, 32'h8001_1234, 1, -1);
        checks++; if (o_sel !== 4'b1100 || o_addr !== 32'h100) $display("FAIL lh_sel_addr got %b/%h exp 1100/100", o_sel, o_addr); else passes++;
        checks++; if (o_wdata_done !== 32'hFFFF_8001) $display("FAIL lh_wdata got %h exp ffff8001", o_wdata_done); else passes++;
    endtask

    task automatic test_store();
        run_op(EXE_SB_OP, 32'h301, 32'h0000_00A5, 32'h0, 0, -1);
        checks++; if (o_we !== 1'b1) $display("FAIL sb_we got %b exp 1", o_we); else passes++;
        checks++; if (o_sel !== 4'b0100) $display("FAIL sb_sel got %b exp 0100", o_sel); else passes++;
        checks++; if (o_bwdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", o_bwdata); else passes++;
        checks++; if (o_wreg_done !== 1'b0) $display("FAIL sb_wreg got %b exp 0", o_wreg_done); else passes++;
        run_op(EXE_SH_OP, 32'h102, 32'h0000_BEEF, 32'h0, 1, -1);
        checks++; if (o_sel !== 4'b0011 || o_bwdata !== 32'hBEEF_BEEF) $display("FAIL sh_bus got %b/%h exp 0011/beefbeef", o_sel, o_bwdata); else passes++;
        run_op(EXE_SW_OP, 32'h500, 32'h1234_5678, 32'h0, 0, -1);
        checks++; if (o_sel !== 4'b1111 || o_bwdata !== 32'h1234_5678) $display("FAIL sw_bus got %b/%h exp 1111/12345678", o_sel, o_bwdata); else passes++;
    endtask

    task automatic test_flush_req();
        run_op(EXE_LW_OP, 32'h700, 32'h0, 32'h0BAD_F00D, 3, 0);
        checks++; if (req_cnt !== 4) $display("FAIL flush_req_cycles got %0d exp 4", req_cnt); else passes++;
        checks++; if (held_ok !== 1'b1) $display("FAIL flush_bus_held got %b exp 1", held_ok); else passes++;
        checks++; if (done_seen !== 1'b1 || o_wreg_done !== 1'b0) $display("FAIL flush_done_wreg got %b/%b exp 1/0", done_seen, o_wreg_done); else passes++;
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        valid = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; #1;
        checks++; if (breq !== 1'b0 || stall !== 1'b0) $display("FAIL spurious_ack got %b%b exp 00", breq, stall); else passes++;
    endtask

    task automatic test_back_to_back();
        run_op(EXE_LBU_OP, 32'h102, 32'h0, 32'h1122_3344, 0, -1);
        checks++; if (o_sel !== 4'b0010 || o_wdata_done !== 32'h33) $display("FAIL b2b_lbu got %b/%h exp 0010/00000033", o_sel, o_wdata_done); else passes++;
        run_op(EXE_LW_OP, 32'h204, 32'h0, 32'hCAFE_F00D, 1, -1);
        checks++; if (o_addr !== 32'h204 || o_wdata_done !== 32'hCAFE_F00D) $display("FAIL b2b_lw got %h/%h exp 204/cafef00d", o_addr, o_wdata_done); else passes++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid = 1'b1; aluop = EXE_LW_OP; addr = 32'h600; wreg = 1'b1; ack = 1'b0;
        @(negedge clk); #1;
        checks++; if (breq !== 1'b1) $display("FAIL rmid_in_req got %b exp 1", breq); else passes++;
        rst = 1'b1; #1;
        checks++; if (breq !== 1'b0 || stall !== 1'b0) $display("FAIL rmid_drop got %b%b exp 00", breq, stall); else passes++;
        checks++; if (bsel !== 4'b0 || baddr !== 32'h0) $display("FAIL rmid_bus got %b/%h exp 0000/0", bsel, baddr); else passes++;
        valid = 1'b0; aluop = EXE_NOP_OP;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (breq !== 1'b0 || stall !== 1'b0) $display("FAIL rmid_idle got %b%b exp 00", breq, stall); else passes++;
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        valid = 1'b1; aluop = EXE_LW_OP; addr = 32'h402; wreg = 1'b1; flush = 1'b0; #1;
        checks++; if (excp !== 1'b1) $display("FAIL mis_excp got %b exp 1", excp); else passes++;
        checks++; if (breq !== 1'b0 || stall !== 1'b0 || wreg_o !== 1'b0) $display("FAIL mis_quiet got %b%b%b exp 000", breq, stall, wreg_o); else passes++;
        @(negedge clk);
        valid = 1'b0; aluop = EXE_NOP_OP; #1;
        checks++; if (excp !== 1'b0 || breq !== 1'b0) $display("FAIL mis_after got %b%b exp 00", excp, breq); else passes++;
`else
        run_op(EXE_LW_OP, 32'h402, 32'h0, 32'h0102_0304, 0, -1);
        checks++; if (o_sel !== 4'b1111 || o_addr !== 32'h400) $display("FAIL lw_forced_align got %b/%h exp 1111/400", o_sel, o_addr); else passes++;
        checks++; if (o_wdata_done !== 32'h0102_0304) $display("FAIL lw_forced_data got %h exp 01020304", o_wdata_done); else passes++;
`endif
    endtask

    task automatic test_dw64();
        run_op64(EXE_LW_OP, 32'h1004, 64'h0, 64'h0000_0000_8000_0000);
        checks++; if (done64 !== 1'b1) $display("FAIL dw64_timeout got %b exp 1", done64); else passes++;
        checks++; if (o_sel64 !== 8'b0000_1111) $display("FAIL dw64_lw_sel got %b exp 00001111", o_sel64); else passes++;
        checks++; if (o_addr64 !== 32'h1000) $display("FAIL dw64_lw_addr got %h exp 1000", o_addr64); else passes++;
        checks++; if (o_wdata64 !== 64'hFFFF_FFFF_8000_0000) $display("FAIL dw64_lw_wdata got %h exp ffffffff80000000", o_wdata64); else passes++;
        checks++; if (o_wreg64 !== 1'b1) $display("FAIL dw64_lw_wreg got %b exp 1", o_wreg64); else passes++;
        run_op64(EXE_SB_OP, 32'h7, 64'h5A, 64'h0);
        checks++; if (o_sel64 !== 8'b0000_0001 || o_bwdata64 !== 64'h5A5A_5A5A_5A5A_5A5A) $display("FAIL dw64_sb got %b/%h exp 00000001/5a5a5a5a5a5a5a5a", o_sel64, o_bwdata64); else passes++;
        checks++; if (o_wreg64 !== 1'b0) $display("FAIL dw64_sb_wreg got %b exp 0", o_wreg64); else passes++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_halfword();
        test_store();
        test_flush_req();
        test_spurious_ack();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_dw64();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
